// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, FSM states and line-address helper for the L1 data cache
package dcache_pkg;

    localparam int TAG_W      = 23;
    localparam int IDX_W      = 4;
    localparam int OFF_W      = 5;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int SEL_W      = 3;
    localparam int SRAM_TAG_W = 25;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_READMISS,
        ST_READMISSOK
    } dcache_state_e;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// rtl/dcache_word_mux.sv - extract one 32-bit word from a cache line and merge one back in
module dcache_word_mux
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [SEL_W-1:0]  sel,
    input  logic [WORD_W-1:0] wr_word,
    output logic [WORD_W-1:0] rd_word,
    output logic [LINE_W-1:0] merged_line
);

    always_comb begin
        rd_word                          = line[WORD_W*sel +: WORD_W];
        merged_line                      = line;
        merged_line[WORD_W*sel +: WORD_W] = wr_word;
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - L1 data cache control: zero-stall hits, write-back/refill on miss
// The held CPU request is replayed as a hit once the refilled line is in the SRAM.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    output logic [IDX_W-1:0]      sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,
    output logic [31:0]           mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i
);

    dcache_state_e     state, state_next;
    logic [TAG_W-1:0]  victim_tag;
    logic [LINE_W-1:0] victim_data;
    logic [LINE_W-1:0] merged_line;

    logic              req;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [1:0]        unused_byte_off;

    assign req             = cpu_MemRead_i | cpu_MemWrite_i;
    assign cpu_tag         = cpu_addr_i[31:9];
    assign cpu_idx         = cpu_addr_i[8:5];
    assign unused_byte_off = cpu_addr_i[1:0];
    assign sram_enable_o   = req;
    assign sram_addr_o     = cpu_idx;

    dcache_word_mux u_word_mux (
        .line        (sram_data_i),
        .sel         (cpu_addr_i[4:2]),
        .wr_word     (cpu_data_i),
        .rd_word     (cpu_data_o),
        .merged_line (merged_line)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            victim_tag  <= '0;
            victim_data <= '0;
        end else begin
            state <= state_next;
            if (state == ST_MISS) begin
                victim_tag  <= sram_tag_i[TAG_W-1:0];
                victim_data <= sram_data_i;
            end
        end
    end

    always_comb begin
        state_next   = state;
        cpu_stall_o  = 1'b0;
        sram_write_o = 1'b0;
        sram_tag_o   = {1'b0, 1'b0, cpu_tag};
        sram_data_o  = merged_line;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = line_addr(cpu_tag, cpu_idx);
        mem_data_o   = victim_data;

        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    if (sram_hit_i) begin
                        if (cpu_MemWrite_i) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_next  = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                // SRAM is presenting the LRU victim this cycle; decide from it directly.
                cpu_stall_o = 1'b1;
                if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                    state_next = ST_WRITEBACK;
                end else begin
                    state_next = ST_READMISS;
                end
            end
            ST_WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = line_addr(victim_tag, cpu_idx);
                if (mem_ack_i) begin
                    state_next = ST_READMISS;
                end
            end
            ST_READMISS: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                if (mem_ack_i) begin
                    sram_write_o = 1'b1;
                    sram_data_o  = mem_data_i;
                    sram_tag_o   = {1'b1, 1'b0, cpu_tag};
                    state_next   = ST_READMISSOK;
                end
            end
            ST_READMISSOK: begin
                cpu_stall_o = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - vector table plus scoreboard bench for dcache_controller
module tb_dcache_controller;

    logic         clk_i, rst_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // 2-way, 16-set SRAM with LRU victim selection
    logic [24:0]  tags  [16][2];
    logic [255:0] lines [16][2];
    logic         lru   [16];
    logic         mdl_clear;
    logic         hit0, hit1, mdl_way;

    always_comb begin
        hit0       = tags[sram_addr_o][0][24] && (tags[sram_addr_o][0][22:0] == sram_tag_o[22:0]);
        hit1       = tags[sram_addr_o][1][24] && (tags[sram_addr_o][1][22:0] == sram_tag_o[22:0]);
        sram_hit_i = sram_enable_o && (hit0 || hit1);
        mdl_way    = hit0 ? 1'b0 : (hit1 ? 1'b1 : lru[sram_addr_o]);
        sram_tag_i = tags[sram_addr_o][mdl_way];
        sram_data_i = lines[sram_addr_o][mdl_way];
    end

    always_ff @(posedge clk_i) begin
        if (mdl_clear) begin
            for (int s = 0; s < 16; s++) begin
                lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    tags[s][w]  <= '0;
                    lines[s][w] <= '0;
                end
            end
        end else if (sram_enable_o) begin
            if (sram_write_o) begin
                tags[sram_addr_o][mdl_way]  <= sram_tag_o;
                lines[sram_addr_o][mdl_way] <= sram_data_o;
            end
            if (sram_write_o || sram_hit_i) lru[sram_addr_o] <= ~mdl_way;
        end
    end

    // Reference memory image and scoreboards
    logic [31:0]  ref_w [logic [31:0]];
    logic [255:0] mem   [logic [31:0]];
    typedef struct { logic [31:0] addr; logic [255:0] data; } wb_t;
    wb_t          wb_q[$];
    logic [31:0]  rd_q[$];

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = k[2:0];
            l[32*k +: 32] = {a[31:5], kk, 2'b00} ^ 32'h5A5A_0000;
        end
        if (a == 32'h40) l[31:0] = 32'hDEADBEEF;
        return l;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0]  wa;
        logic [255:0] l;
        wa = {a[31:2], 2'b00};
        if (ref_w.exists(wa)) return ref_w[wa];
        l = init_line({a[31:5], 5'b0});
        return l[32*a[4:2] +: 32];
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = ref_rd(la + 32'(4*k));
        return l;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_line(a);
    endfunction

    // Memory responder: acks after ack_delay enabled cycles
    int ack_delay;
    bit inject_ack;

    initial begin
        int cnt;
        wb_t e;
        cnt        = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (inject_ack) begin
                mem_ack_i = 1'b1;
            end else if (rst_i || !mem_enable_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt       = 0;
                    mem_ack_i = 1'b1;
                    if (mem_write_o) begin
                        if (wb_q.size() == 0) begin
                            chk("wb_unexpected", 1'b1, 1'b0);
                        end else begin
                            e = wb_q.pop_front();
                            chk("wb_addr", mem_addr_o, e.addr);
                            chk("wb_data", mem_data_o, e.data);
                        end
                        mem[mem_addr_o] = mem_data_o;
                    end else begin
                        mem_data_i = get_line(mem_addr_o);
                    end
                end
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          miss;
        bit          wb;
        logic [31:0] wb_addr;
        int          dly;
    } vec_t;
    vec_t vecs[12];

    task automatic run_vec(input vec_t v);
        int           lat, exp_lat;
        bit           wb_seen;
        logic [255:0] exp_line;
        logic [31:0]  exp_rd;
        ack_delay = v.dly;
        exp_lat   = !v.miss ? 0 : (v.wb ? 2*v.dly + 3 : v.dly + 3);
        exp_line  = '0;
        if (v.wr) begin
            exp_line = ref_line({v.addr[31:5], 5'b0});
            exp_line[32*v.addr[4:2] +: 32] = v.wdata;
        end else begin
            rd_q.push_back(ref_rd(v.addr));
        end
        if (v.wb) wb_q.push_back('{v.wb_addr, ref_line(v.wb_addr)});
        cpu_addr_i     = v.addr;
        cpu_data_i     = v.wdata;
        cpu_MemRead_i  = !v.wr;
        cpu_MemWrite_i = v.wr;
        lat     = 0;
        wb_seen = 0;
        forever begin
            @(negedge clk_i);
            #1;
            if (v.miss && lat == 1) chk("miss_state_en", mem_enable_o, 1'b0);
            if (v.miss && lat == 2) chk("first_mem_req", {mem_enable_o, mem_write_o}, {1'b1, v.wb});
            if (mem_enable_o && mem_write_o) wb_seen = 1;
            if (sram_write_o && cpu_stall_o) begin
                chk("refill_on_ack", mem_ack_i, 1'b1);
                chk("refill_tag", sram_tag_o, {2'b10, v.addr[31:9]});
                chk("refill_addr", mem_addr_o, {v.addr[31:5], 5'b0});
                chk("refill_data", sram_data_o, mem_data_i);
            end
            if (!cpu_stall_o) break;
            lat++;
            if (lat > 400) begin
                chk("stall_timeout", 1'b1, 1'b0);
                break;
            end
        end
        chk("latency", lat, exp_lat);
        chk("wb_phase", wb_seen, v.wb);
        chk("idle_mem_en", mem_enable_o, 1'b0);
        if (v.wr) begin
            chk("st_write", sram_write_o, 1'b1);
            chk("st_tag", sram_tag_o, {2'b11, v.addr[31:9]});
            chk("st_line", sram_data_o, exp_line);
            ref_w[{v.addr[31:2], 2'b00}] = v.wdata;
        end else begin
            chk("ld_no_write", sram_write_o, 1'b0);
            exp_rd = rd_q.pop_front();
            chk("ld_data", cpu_data_o, exp_rd);
        end
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        mdl_clear      = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        inject_ack     = 1'b0;
        ack_delay      = 4;

        //          wr  addr          wdata         miss wb  wb_addr      dly
        vecs[0]  = '{0, 32'h0000_0040, 32'h0,        1, 0, 32'h0,        10};
        vecs[1]  = '{0, 32'h0000_0040, 32'h0,        0, 0, 32'h0,        1};
        vecs[2]  = '{1, 32'h0000_0044, 32'h12345678, 0, 0, 32'h0,        1};
        vecs[3]  = '{1, 32'h0000_0240, 32'hAAAA0001, 1, 0, 32'h0,        3};
        vecs[4]  = '{0, 32'h0000_0440, 32'h0,        1, 1, 32'h0000_0040, 1};
        vecs[5]  = '{0, 32'h0000_0044, 32'h0,        1, 1, 32'h0000_0240, 2};
        vecs[6]  = '{0, 32'h0000_0448, 32'h0,        0, 0, 32'h0,        1};
        vecs[7]  = '{1, 32'h0000_1068, 32'hCAFEF00D, 1, 0, 32'h0,        4};
        vecs[8]  = '{0, 32'h0000_1068, 32'h0,        0, 0, 32'h0,        1};
        vecs[9]  = '{0, 32'h0000_107C, 32'h0,        0, 0, 32'h0,        1};
        vecs[10] = '{1, 32'h0000_1060, 32'h0BADF00D, 0, 0, 32'h0,        1};
        vecs[11] = '{0, 32'h0000_1068, 32'h0,        0, 0, 32'h0,        1};

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_mem_en", mem_enable_o, 1'b0);
        chk("rst_mem_wr", mem_write_o, 1'b0);
        chk("rst_sram_wr", sram_write_o, 1'b0);
        chk("rst_sram_en", sram_enable_o, 1'b0);
        rst_i     = 1'b0;
        mdl_clear = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset in the middle of a refill
        ack_delay      = 50;
        cpu_addr_i     = 32'h2000_0060;
        cpu_MemRead_i  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            #1;
            if (mem_enable_o) break;
        end
        chk("rm_en_before_rst", {mem_enable_o, mem_write_o}, 2'b10);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rm_rst_en_drop", mem_enable_o, 1'b0);
        chk("rm_rst_stall", cpu_stall_o, 1'b1);
        cpu_MemRead_i = 1'b0;
        #1;
        chk("rm_rst_idle", cpu_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        inject_ack = 1'b1;
        @(negedge clk_i);
        #1;
        inject_ack = 1'b0;
        chk("stray_ack_sram_wr", sram_write_o, 1'b0);
        @(negedge clk_i);
        #1;
        chk("stray_ack_mem_en", mem_enable_o, 1'b0);
        chk("stray_ack_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i);
        #1;

        run_vec(vecs[11]);

        chk("rd_q_empty", rd_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
